// File: rtl/pe_ctrl_pkg.sv
// Shared types and helpers for the PE array sequencer.
package pe_ctrl_pkg;

  localparam int NUM_PE_DEF = 12;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_LOAD_W   = 3'd2,
    ST_LOAD_D   = 3'd3,
    ST_COMPUTE  = 3'd4,
    ST_WAIT_ACC = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  // One-hot decode of a PE index; callers size-cast to their strobe width.
  function automatic logic [31:0] onehot(input logic [31:0] idx);
    onehot = 32'd1 << idx;
  endfunction

endpackage

// File: rtl/pe_stream_loader.sv
// Valid/ready acceptor that walks a PE index and drives a registered bus
// plus a one-hot capture strobe. A sample accepted in cycle t appears on
// bus/strobe in cycle t+1. last_accept flags the accept that ends the load
// (index NUM_PE-1, or the only accept when single is set).
module pe_stream_loader
  import pe_ctrl_pkg::*;
#(
  parameter int NUM_PE = NUM_PE_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              ready,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic              single,
  output logic [DATA_W-1:0] bus,
  output logic [NUM_PE-1:0] strobe,
  output logic              last_accept
);

  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] bus_q, bus_d;
  logic [NUM_PE-1:0] strobe_q, strobe_d;
  logic              accept;

  // Accept logic: strobe only on a handshake, index holds through stalls.
  always_comb begin
    accept      = ready & valid;
    idx_d       = idx_q;
    bus_d       = bus_q;
    strobe_d    = '0;
    last_accept = 1'b0;
    if (clr) begin
      idx_d = '0;
    end else if (accept) begin
      bus_d       = data;
      strobe_d    = NUM_PE'(onehot(32'(idx_q)));
      last_accept = single || (idx_q == IDX_W'(NUM_PE - 1));
      idx_d       = last_accept ? '0 : idx_q + 1'b1;
    end
  end

  // Index, bus and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      bus_q    <= '0;
      strobe_q <= '0;
    end else begin
      idx_q    <= idx_d;
      bus_q    <= bus_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus    = bus_q;
  assign strobe = strobe_q;

endmodule

// File: rtl/pe_array_ctrl.sv
// Sequencer for a 12-PE array: clear, load weights, then per window load
// data (full or one-sample slide), fire compute, wait for the accumulator.
// Handshake rule: a sample moves when valid and ready are both high at a
// rising edge; ready is registered and never depends on valid in the same
// cycle, and w_ready/d_ready are only high in their own load state.
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int NUM_PE  = NUM_PE_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_windows,
  input  logic              slide_mode,
  output logic              busy,
  output logic              done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [DATA_W-1:0] d_data,
  output logic [DATA_W-1:0] weight_bus,
  output logic [DATA_W-1:0] data_bus,
  output logic [NUM_PE-1:0] pe_rst,
  output logic [NUM_PE-1:0] pe_enable,
  output logic [NUM_PE-1:0] pe_read_weight,
  output logic [NUM_PE-1:0] pe_read_data,
  output logic [NUM_PE-1:0] pe_fwd_en,
  output logic              acc_valid,
  output logic [2:0]        state_dbg
);

  localparam int ACC_W = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
  localparam logic [NUM_PE-1:0] FWD_MASK = {{(NUM_PE-1){1'b1}}, 1'b0};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  win_rem_q, win_rem_d;
  logic              slide_q, slide_d;
  logic              first_q, first_d;
  logic [ACC_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              w_ready_q, w_ready_d, d_ready_q, d_ready_d;
  logic              acc_valid_q, acc_valid_d;
  logic [NUM_PE-1:0] pe_rst_q, pe_rst_d, pe_enable_q, pe_enable_d;
  logic [NUM_PE-1:0] fwd_q, fwd_d;
  logic              w_last, d_last, slide_win, d_accept;

  assign slide_win = slide_q & ~first_q;
  assign d_accept  = d_valid & d_ready_q;

  pe_stream_loader #(.NUM_PE(NUM_PE), .DATA_W(DATA_W)) u_w_loader (
    .clk(clk), .rst_n(rst_n), .clr(state_q != ST_LOAD_W),
    .ready(w_ready_q), .valid(w_valid), .data(w_data), .single(1'b0),
    .bus(weight_bus), .strobe(pe_read_weight), .last_accept(w_last)
  );

  pe_stream_loader #(.NUM_PE(NUM_PE), .DATA_W(DATA_W)) u_d_loader (
    .clk(clk), .rst_n(rst_n), .clr(state_q != ST_LOAD_D),
    .ready(d_ready_q), .valid(d_valid), .data(d_data), .single(slide_win),
    .bus(data_bus), .strobe(pe_read_data), .last_accept(d_last)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    win_rem_d   = win_rem_q;
    slide_d     = slide_q;
    first_d     = first_q;
    acc_cnt_d   = acc_cnt_q;
    acc_valid_d = 1'b0;
    fwd_d       = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          win_rem_d = num_windows;
          slide_d   = slide_mode;
          first_d   = 1'b1;
          state_d   = (num_windows == '0) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR:   state_d = ST_LOAD_W;
      ST_LOAD_W:  if (w_last) state_d = ST_LOAD_D;
      ST_LOAD_D: begin
        if (d_accept && slide_win) fwd_d = FWD_MASK;
        if (d_last) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        acc_cnt_d = ACC_W'(ACC_LAT - 1);
        state_d   = ST_WAIT_ACC;
      end
      ST_WAIT_ACC: begin
        if (acc_cnt_q == '0) begin
          acc_valid_d = 1'b1;
          win_rem_d   = win_rem_q - 1'b1;
          first_d     = 1'b0;
          state_d     = (win_rem_q == CNT_W'(1)) ? ST_DONE : ST_LOAD_D;
        end else begin
          acc_cnt_d = acc_cnt_q - 1'b1;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    w_ready_d   = (state_d == ST_LOAD_W);
    d_ready_d   = (state_d == ST_LOAD_D);
    pe_rst_d    = (state_d == ST_CLEAR) ? '1 : '0;
    // Enable follows the COMPUTE state so it lands after the last data strobe.
    pe_enable_d = (state_q == ST_COMPUTE) ? '1 : '0;
  end

  // State and output registers; PEs held clear while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      win_rem_q   <= '0;
      slide_q     <= 1'b0;
      first_q     <= 1'b0;
      acc_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      w_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      acc_valid_q <= 1'b0;
      pe_rst_q    <= '1;
      pe_enable_q <= '0;
      fwd_q       <= '0;
    end else begin
      state_q     <= state_d;
      win_rem_q   <= win_rem_d;
      slide_q     <= slide_d;
      first_q     <= first_d;
      acc_cnt_q   <= acc_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      w_ready_q   <= w_ready_d;
      d_ready_q   <= d_ready_d;
      acc_valid_q <= acc_valid_d;
      pe_rst_q    <= pe_rst_d;
      pe_enable_q <= pe_enable_d;
      fwd_q       <= fwd_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign w_ready   = w_ready_q;
  assign d_ready   = d_ready_q;
  assign acc_valid = acc_valid_q;
  assign pe_rst    = pe_rst_q;
  assign pe_enable = pe_enable_q;
  assign pe_fwd_en = fwd_q;
  assign state_dbg = state_q;

endmodule
